// File: rtl/vector_division_iterative_unit_pkg.sv
// Shared types for the iterative vector divider: mode encodings, FSM states and SEW decode.
package vector_division_iterative_unit_pkg;

    typedef enum logic [1:0] {
        BIT_MODE_8  = 2'd0,
        BIT_MODE_16 = 2'd1,
        BIT_MODE_32 = 2'd2,
        BIT_MODE_64 = 2'd3
    } bit_mode_t;

    typedef enum logic [1:0] {
        SIGN_UU = 2'd0,
        SIGN_SU = 2'd1,
        SIGN_US = 2'd2,
        SIGN_SS = 2'd3
    } sign_mode_t;

    typedef struct packed {
        logic       remainder_mode;
        sign_mode_t sign_mode;
        bit_mode_t  bit_mode;
    } execution_vector_t;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} vdiv_state_t;

    localparam int unsigned NUM_SEW = 4;

    function automatic int unsigned sew_of(bit_mode_t bit_mode);
        return 32'd8 << bit_mode;
    endfunction

endpackage

// File: rtl/vector_division_iterative_unit_if.sv
// Request/response bundle of the iterative vector divider, plus its FSM state for observation.
interface vector_division_iterative_unit_if
    import vector_division_iterative_unit_pkg::*;
#(
    parameter int ELEN = 64
) ();
    logic              in_valid;
    logic              in_ready;
    execution_vector_t execution_vector;
    logic [ELEN-1:0]   vs2;
    logic [ELEN-1:0]   vs1;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [ELEN-1:0]   vd;
    vdiv_state_t       debug_state;

    // A transfer occurs on each rising edge where valid and ready are both high; a raised
    // valid keeps its payload stable until that edge (only abort withdraws a pending result).
    modport master (
        output in_valid, execution_vector, vs2, vs1, abort, out_ready,
        input  in_ready, out_valid, vd, debug_state
    );
    modport slave (
        input  in_valid, execution_vector, vs2, vs1, abort, out_ready,
        output in_ready, out_valid, vd, debug_state
    );
endinterface

// File: rtl/vector_division_iterative_unit_step.sv
// One radix-2 restoring division step over ELEN bits, segmented into independent SEW lanes.
module vector_division_iterative_unit_step
    import vector_division_iterative_unit_pkg::*;
#(
    parameter int ELEN = 64
) (
    input  bit_mode_t       bit_mode_i,
    input  logic [ELEN-1:0] rem_i,
    input  logic [ELEN-1:0] quo_i,
    input  logic [ELEN-1:0] dsr_i,
    output logic [ELEN-1:0] rem_o,
    output logic [ELEN-1:0] quo_o
);
    logic [NUM_SEW-1:0][ELEN-1:0] rem_g;
    logic [NUM_SEW-1:0][ELEN-1:0] quo_g;

    for (genvar g = 0; g < NUM_SEW; g++) begin : g_sew
        localparam int W = 8 << g;
        for (genvar l = 0; l < ELEN / W; l++) begin : g_lane
            logic [W-1:0] r;
            logic [W-1:0] q;
            logic [W-1:0] d;
            logic [W+1:0] diff;
            assign r = rem_i[l*W +: W];
            assign q = quo_i[l*W +: W];
            assign d = dsr_i[l*W +: W];
            // The shifted partial remainder needs one bit beyond the lane width.
            assign diff = {1'b0, r, q[W-1]} - {2'b00, d};
            assign rem_g[g][l*W +: W] = diff[W+1] ? {r[W-2:0], q[W-1]} : diff[W-1:0];
            assign quo_g[g][l*W +: W] = {q[W-2:0], ~diff[W+1]};
        end
    end

    assign rem_o = rem_g[bit_mode_i];
    assign quo_o = quo_g[bit_mode_i];
endmodule

// File: rtl/vector_division_iterative_unit.sv
// Multi-cycle lane-parallel integer divider: PREP takes magnitudes, ITER runs SEW restoring steps,
// FIX applies signs and RISC-V V special cases.
module vector_division_iterative_unit
    import vector_division_iterative_unit_pkg::*;
#(
    parameter int ELEN    = 64,
    parameter int MAX_SEW = 64
) (
    input logic                            clock,
    input logic                            reset,
    vector_division_iterative_unit_if.slave bus
);
    localparam int NL = ELEN / 8;
    localparam int CW = $clog2(MAX_SEW);

    vdiv_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ELEN-1:0]   vd_q, vd_d;
    execution_vector_t mode_q;
    logic [ELEN-1:0]   vs2_q, vs1_q, rem_q, quo_q, dsr_q;
    logic [NL-1:0]     qneg_q, rneg_q, dz_q, ov_q;
    logic              signed_mode, supported;
    logic [ELEN-1:0]   step_rem, step_quo;

    logic [NUM_SEW-1:0][ELEN-1:0] a_mag_g, b_mag_g, res_g;
    logic [NUM_SEW-1:0][NL-1:0]   qneg_g, rneg_g, dz_g, ov_g;

    assign signed_mode = (mode_q.sign_mode == SIGN_SS);
    assign supported   = signed_mode | (mode_q.sign_mode == SIGN_UU);

    // Per-lane flags are replicated over every byte of the lane, so lane l always reads byte l*B.
    for (genvar g = 0; g < NUM_SEW; g++) begin : g_sew
        localparam int W = 8 << g;
        localparam int B = W / 8;
        for (genvar l = 0; l < ELEN / W; l++) begin : g_lane
            logic [W-1:0] a, b, q, r, q_s, r_s;
            logic         a_neg, b_neg, dz, ov;
            assign a     = vs2_q[l*W +: W];
            assign b     = vs1_q[l*W +: W];
            assign a_neg = signed_mode & a[W-1];
            assign b_neg = signed_mode & b[W-1];
            assign dz    = (b == '0);
            assign ov    = signed_mode & (a == {1'b1, {(W-1){1'b0}}}) & (b == '1);
            assign a_mag_g[g][l*W +: W] = a_neg ? -a : a;
            assign b_mag_g[g][l*W +: W] = b_neg ? -b : b;
            assign qneg_g[g][l*B +: B]  = {B{a_neg ^ b_neg}};
            assign rneg_g[g][l*B +: B]  = {B{a_neg}};
            assign dz_g[g][l*B +: B]    = {B{dz}};
            assign ov_g[g][l*B +: B]    = {B{ov}};

            assign q   = quo_q[l*W +: W];
            assign r   = rem_q[l*W +: W];
            assign q_s = qneg_q[l*B] ? -q : q;
            assign r_s = rneg_q[l*B] ? -r : r;
            assign res_g[g][l*W +: W] =
                dz_q[l*B] ? (mode_q.remainder_mode ? a : '1) :
                ov_q[l*B] ? (mode_q.remainder_mode ? '0 : a) :
                            (mode_q.remainder_mode ? r_s : q_s);
        end
    end

    vector_division_iterative_unit_step #(.ELEN(ELEN)) u_step (
        .bit_mode_i (mode_q.bit_mode),
        .rem_i      (rem_q),
        .quo_i      (quo_q),
        .dsr_i      (dsr_q),
        .rem_o      (step_rem),
        .quo_o      (step_quo)
    );

    assign vd_d = supported ? res_g[mode_q.bit_mode] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = PREP;
            PREP: state_d = supported ? ITER : FIX;
            ITER: begin
                if (cnt_q == CW'(sew_of(mode_q.bit_mode) - 1)) state_d = FIX;
                else cnt_d = cnt_q + 1'b1;
            end
            FIX:  state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == FIX && !bus.abort) vd_q <= vd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == IDLE && bus.in_valid) begin
            mode_q <= bus.execution_vector;
            vs2_q  <= bus.vs2;
            vs1_q  <= bus.vs1;
        end
        if (state_q == PREP) begin
            rem_q  <= '0;
            quo_q  <= a_mag_g[mode_q.bit_mode];
            dsr_q  <= b_mag_g[mode_q.bit_mode];
            qneg_q <= qneg_g[mode_q.bit_mode];
            rneg_q <= rneg_g[mode_q.bit_mode];
            dz_q   <= dz_g[mode_q.bit_mode];
            ov_q   <= ov_g[mode_q.bit_mode];
        end else if (state_q == ITER) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.vd          = vd_q;
    assign bus.debug_state = state_q;
endmodule

// File: tb/tb_vector_division_iterative_unit.sv
// Bench for the iterative vector divider: vector table through a scoreboard, plus abort/reset/stall corners.
module tb_vector_division_iterative_unit;
    import vector_division_iterative_unit_pkg::*;

    localparam int ELEN = 64;

    typedef struct {
        execution_vector_t ev;
        logic [ELEN-1:0]   a;
        logic [ELEN-1:0]   b;
        logic [ELEN-1:0]   expv;
        int                lat;
        int                stall;
    } vec_t;

    logic            clock = 1'b0;
    logic            reset;
    logic [ELEN-1:0] exp_q[$];
    vec_t            vecs[16];
    int              nv = 0;
    int              checks = 0;
    int              errors = 0;

    vector_division_iterative_unit_if #(.ELEN(ELEN)) bus ();

    vector_division_iterative_unit #(.ELEN(ELEN), .MAX_SEW(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic execution_vector_t mk(input logic rem, input sign_mode_t sm, input bit_mode_t bm);
        execution_vector_t e;
        e.remainder_mode = rem;
        e.sign_mode      = sm;
        e.bit_mode       = bm;
        return e;
    endfunction

    task automatic add(input execution_vector_t ev, input logic [ELEN-1:0] a, input logic [ELEN-1:0] b,
                       input logic [ELEN-1:0] expv, input int lat, input int stall);
        vecs[nv].ev    = ev;
        vecs[nv].a     = a;
        vecs[nv].b     = b;
        vecs[nv].expv  = expv;
        vecs[nv].lat   = lat;
        vecs[nv].stall = stall;
        nv++;
    endtask

    task automatic check(input string name, input logic [ELEN-1:0] act, input logic [ELEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Driver: present one request, let it be accepted, then scramble the now don't-care inputs.
    task automatic drive_req(input execution_vector_t ev, input logic [ELEN-1:0] a,
                             input logic [ELEN-1:0] b, input logic [ELEN-1:0] expv, input bit track);
        logic [4:0] junk;
        if (track) exp_q.push_back(expv);
        bus.execution_vector = ev;
        bus.vs2              = a;
        bus.vs1              = b;
        bus.in_valid         = 1'b1;
        check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        cycle();
        bus.in_valid         = 1'b0;
        junk                 = 5'($urandom_range(0, 31));
        bus.execution_vector = junk;
        bus.vs2              = {$urandom, $urandom};
        bus.vs1              = {$urandom, $urandom};
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            cycle();
            lat++;
        end
    endtask

    // Scoreboard side: pop the expected value when out_valid appears, hold through a stall, handshake.
    task automatic collect(input string tag, input int exp_lat, input int stall);
        int              lat;
        logic [ELEN-1:0] expv;
        wait_valid(lat);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        expv = '0;
        if (exp_q.size() != 0) expv = exp_q.pop_front();
        check({tag, "_vd"}, bus.vd, expv);
        for (int s = 0; s < stall; s++) begin
            cycle();
            check({tag, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_stall_in_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, "_stall_vd"}, bus.vd, expv);
        end
        check({tag, "_in_ready_in_done"}, 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        check({tag, "_valid_after_hs"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready_after_hs"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int stray;
        bus.in_valid         = 1'b0;
        bus.execution_vector = '0;
        bus.vs2              = '0;
        bus.vs1              = '0;
        bus.abort            = 1'b0;
        bus.out_ready        = 1'b0;
        reset                = 1'b1;

        add(mk(0, SIGN_UU, BIT_MODE_8),  64'h6464646464646464, 64'h0707070707070707, 64'h0E0E0E0E0E0E0E0E, 10, 0);
        add(mk(1, SIGN_UU, BIT_MODE_8),  64'h6464646464646464, 64'h0707070707070707, 64'h0202020202020202, 10, 0);
        add(mk(0, SIGN_SS, BIT_MODE_32), 64'h00000007FFFFFFF9, 64'hFFFFFFFE00000002, 64'hFFFFFFFDFFFFFFFD, 34, 0);
        add(mk(1, SIGN_SS, BIT_MODE_32), 64'h00000007FFFFFFF9, 64'hFFFFFFFE00000002, 64'h00000001FFFFFFFF, 34, 3);
        add(mk(0, SIGN_SS, BIT_MODE_16), 64'hFF9C006412348000, 64'h000700070000FFFF, 64'hFFF2000EFFFF8000, 18, 0);
        add(mk(1, SIGN_SS, BIT_MODE_16), 64'hFF9C006412348000, 64'h000700070000FFFF, 64'hFFFE000212340000, 18, 0);
        add(mk(0, SIGN_UU, BIT_MODE_64), 64'hFFFFFFFFFFFFFFFF, 64'd3,                64'h5555555555555555, 66, 20);
        add(mk(0, SIGN_UU, BIT_MODE_16), 64'hFFFF1000000500FF, 64'h0001001000000010, 64'hFFFF0100FFFF000F, 18, 0);
        add(mk(1, SIGN_UU, BIT_MODE_16), 64'hFFFF1000000500FF, 64'h0001001000000010, 64'h000000000005000F, 18, 1);
        add(mk(0, SIGN_SS, BIT_MODE_8),  64'h9C64FB0580FF7F80, 64'h07F90000FF80FF01, 64'hF2F2FFFF80008180, 10, 0);
        add(mk(1, SIGN_SS, BIT_MODE_8),  64'h9C64FB0580FF7F80, 64'h07F90000FF80FF01, 64'hFE02FB0500FF0000, 10, 0);
        add(mk(0, SIGN_SU, BIT_MODE_32), 64'h1234567890ABCDEF, 64'h0000000300000003, 64'h0000000000000000, 2, 0);
        add(mk(1, SIGN_US, BIT_MODE_8),  64'h6464646464646464, 64'h0707070707070707, 64'h0000000000000000, 2, 0);
        add(mk(0, SIGN_SS, BIT_MODE_64), 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 66, 0);
        add(mk(1, SIGN_SS, BIT_MODE_64), 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 66, 0);

        repeat (3) cycle();
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_vd", bus.vd, 64'd0);
        check("reset_state", 64'(bus.debug_state), 64'(IDLE));
        reset = 1'b0;
        cycle();

        for (int i = 0; i < nv; i++) begin
            drive_req(vecs[i].ev, vecs[i].a, vecs[i].b, vecs[i].expv, 1'b1);
            collect($sformatf("vec%0d", i), vecs[i].lat, vecs[i].stall);
        end

        // Abort at ITER cycle 5: nothing comes out, unit is idle on the next cycle.
        drive_req(vecs[6].ev, vecs[6].a, vecs[6].b, '0, 1'b0);
        repeat (6) cycle();
        check("abort_state_before", 64'(bus.debug_state), 64'(ITER));
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        stray = 0;
        for (int c = 0; c < 80; c++) begin
            if (bus.out_valid) stray++;
            cycle();
        end
        check("abort_no_late_valid", 64'(stray), 64'd0);
        drive_req(vecs[0].ev, vecs[0].a, vecs[0].b, vecs[0].expv, 1'b1);
        collect("after_abort", vecs[0].lat, 0);

        // Abort while idle does not block an accept on the same edge.
        bus.abort = 1'b1;
        drive_req(vecs[2].ev, vecs[2].a, vecs[2].b, vecs[2].expv, 1'b1);
        bus.abort = 1'b0;
        collect("abort_idle", vecs[2].lat, 0);

        // Reset mid-ITER: vd holds a nonzero result beforehand and must clear.
        drive_req(vecs[9].ev, vecs[9].a, vecs[9].b, '0, 1'b0);
        repeat (4) cycle();
        reset = 1'b1;
        cycle();
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_vd", bus.vd, 64'd0);
        check("rst_mid_state", 64'(bus.debug_state), 64'(IDLE));
        reset = 1'b0;
        cycle();

        // abort together with out_ready in DONE drops the result with no extra valid cycle.
        drive_req(vecs[4].ev, vecs[4].a, vecs[4].b, vecs[4].expv, 1'b1);
        wait_valid(lat);
        check("abort_done_latency", 64'(lat), 64'd18);
        if (exp_q.size() != 0) check("abort_done_vd", bus.vd, exp_q.pop_front());
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        check("abort_done_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_done_in_ready", 64'(bus.in_ready), 64'd1);
        cycle();
        check("abort_done_out_valid_next", 64'(bus.out_valid), 64'd0);

        drive_req(vecs[7].ev, vecs[7].a, vecs[7].b, vecs[7].expv, 1'b1);
        collect("final_op", vecs[7].lat, 0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
